// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding and coin denominations.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Value driven on coin_val: one-unit or two-unit coin.
  localparam logic COIN_ONE = 1'b0;
  localparam logic COIN_TWO = 1'b1;

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a loaded credit as a stream of one/two-unit coin requests,
// with a guaranteed one-cycle request gap between coins, cancel and a done pulse.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] amount,
  input  logic         cancel,
  input  logic         coin_ack,
  output logic         coin_req,
  output logic         coin_val,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] remaining
);

  state_e         state_q, state_d;
  logic [n-1:0]   remaining_q, remaining_d;
  logic           coin_req_q, coin_req_d;
  logic           coin_val_q, coin_val_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [n-1:0]   coin_step_c;

  // Units paid by the coin currently being requested.
  assign coin_step_c = (coin_val_q == COIN_TWO) ? n'(2) : n'(1);

  // State and remaining-credit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state and next-remaining logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          remaining_d = amount;
          state_d     = (amount == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (coin_ack) begin
          // Saturating subtract so the credit can never wrap.
          remaining_d = (remaining_q > coin_step_c) ? (remaining_q - coin_step_c) : '0;
          if (remaining_d == '0) begin
            state_d = ST_DONE;
          end else if (cancel) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cancel) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        state_d = cancel ? ST_IDLE : ST_REQ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode, taken from the next state so the outputs can be registered
  // and still line up with the state they describe.
  always_comb begin
    coin_req_d = 1'b0;
    coin_val_d = COIN_ONE;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    if (state_d == ST_REQ) begin
      coin_req_d = 1'b1;
      coin_val_d = (remaining_d >= n'(2)) ? COIN_TWO : COIN_ONE;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coin_req_q <= 1'b0;
      coin_val_q <= COIN_ONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      coin_req_q <= coin_req_d;
      coin_val_q <= coin_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_val  = coin_val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus a per-cycle payout model.
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] amount;
  logic       cancel;
  logic       coin_ack;
  logic       coin_req;
  logic       coin_val;
  logic       busy;
  logic       done;
  logic [3:0] remaining;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 0;

  // Payout model: is a payout running, is it between coins, is the done cycle showing, credit owed.
  bit m_active;
  bit m_between;
  bit m_finish;
  int m_owed;

  change_dispenser #(.n(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .amount    (amount),
    .cancel    (cancel),
    .coin_ack  (coin_ack),
    .coin_req  (coin_req),
    .coin_val  (coin_val),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_active  = 0;
    m_between = 0;
    m_finish  = 0;
    m_owed    = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int coin;
    if (!reset) begin
      m_reset();
    end else if (m_finish) begin
      m_finish = 0;
    end else if (!m_active) begin
      if (load) begin
        m_owed = int'(amount);
        if (m_owed == 0) m_finish = 1;
        else begin
          m_active  = 1;
          m_between = 0;
        end
      end
    end else if (m_between) begin
      if (cancel) m_active = 0;
      else m_between = 0;
    end else begin
      if (coin_ack) begin
        coin = (m_owed >= 2) ? 2 : 1;
        m_owed = m_owed - coin;
        if (m_owed == 0) begin
          m_active = 0;
          m_finish = 1;
        end else if (cancel) begin
          m_active = 0;
        end else begin
          m_between = 1;
        end
      end else if (cancel) begin
        m_active = 0;
      end
    end
  endtask

  // Compare all outputs against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    bit exp_req;
    if (cmp_en) begin
      exp_req = m_active && !m_between;
      chk("model_coin_req", int'(coin_req), int'(exp_req));
      chk("model_coin_val", int'(coin_val), int'(exp_req && (m_owed >= 2)));
      chk("model_busy", int'(busy), int'(m_active || m_finish));
      chk("model_done", int'(done), int'(m_finish));
      chk("model_remaining", int'(remaining), m_owed);
    end
  end

  task automatic step(input logic ld, input logic [3:0] amt, input logic cn, input logic ak);
    load     = ld;
    amount   = amt;
    cancel   = cn;
    coin_ack = ak;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("drain_idle", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[8];
    int rem_hist[32];
    int n_val;
    int done_at;

    reset = 1'b0; load = 1'b0; amount = 4'd0; cancel = 1'b0; coin_ack = 1'b0;
    m_reset();
    #3;
    chk("rst_coin_req", int'(coin_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_remaining", int'(remaining), 0);
    #9 reset = 1'b1;
    cmp_en = 1;

    // amount=5 with ack every request cycle
    step(1'b1, 4'd5, 1'b0, 1'b1);
    n_val = 0;
    done_at = 0;
    for (int i = 1; i <= 20 && done_at == 0; i++) begin
      rem_hist[i] = int'(remaining);
      if (coin_req && n_val < 8) begin
        vals[n_val] = int'(coin_val);
        n_val++;
      end
      if (done) done_at = i;
      else step(1'b0, 4'd0, 1'b0, 1'b1);
    end
    chk("p5_coins", n_val, 3);
    chk("p5_val0", vals[0], 1);
    chk("p5_val1", vals[1], 1);
    chk("p5_val2", vals[2], 0);
    chk("p5_rem_c2", rem_hist[2], 3);
    chk("p5_rem_c4", rem_hist[4], 1);
    chk("p5_done_cycle", done_at, 6);
    chk("p5_rem_end", rem_hist[6], 0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("p5_idle_busy", int'(busy), 0);
    chk("p5_idle_done", int'(done), 0);

    // amount=0 goes straight to the done cycle; cancel in DONE and IDLE is harmless
    step(1'b1, 4'd0, 1'b0, 1'b0);
    chk("z_busy", int'(busy), 1);
    chk("z_done", int'(done), 1);
    chk("z_coin_req", int'(coin_req), 0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("z_back_idle", int'(busy), 0);
    chk("z_done_once", int'(done), 0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("idle_cancel_busy", int'(busy), 0);

    // amount=4 with the mechanism stalling 10 cycles
    step(1'b1, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_coin_req", int'(coin_req), 1);
      chk("stall_coin_val", int'(coin_val), 1);
      step(1'b0, 4'd0, 1'b0, 1'b0);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("stall_rem_after_ack", int'(remaining), 2);
    chk("stall_gap_req", int'(coin_req), 0);
    drain();

    // amount=6, cancel in the gap, then a fresh load of 3
    step(1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("cg_busy", int'(busy), 0);
    chk("cg_remaining", int'(remaining), 4);
    chk("cg_done", int'(done), 0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    chk("cg_l3_val", int'(coin_val), 1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("cg_l3_rem1", int'(remaining), 1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("cg_l3_val2", int'(coin_val), 0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("cg_l3_done", int'(done), 1);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // cancel and ack in the same request cycle
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    chk("ca3_remaining", int'(remaining), 1);
    chk("ca3_busy", int'(busy), 0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    chk("ca1_remaining", int'(remaining), 0);
    chk("ca1_done", int'(done), 1);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // reset mid-payout of 15 after two coins
    step(1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk("mr_pre_rem", int'(remaining), 11);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("mr_coin_req", int'(coin_req), 0);
    chk("mr_coin_val", int'(coin_val), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    chk("mr_remaining", int'(remaining), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      chk("mr_no_done", int'(done), 0);
    end
    reset = 1'b0;
    m_reset();
    #2 reset = 1'b1;
    step(1'b1, 4'd2, 1'b0, 1'b0);
    chk("rel_load_busy", int'(busy), 1);
    chk("rel_load_rem", int'(remaining), 2);
    drain();

    // load while busy is ignored
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    chk("busy_load_rem", int'(remaining), 5);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("busy_load_cancel", int'(busy), 0);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
